wave_sequencer: RTL
===================

// Module: wave_sequencer
// PURPOSE
//  Round-robin scheduler sharing one wave generator (mode/step_size/reset/5-bit out) among N_REQ requesters.
//  Each request is a burst: mode, step, number of 32-cycle periods.
//  Grants one requester at a time, resets and configures the generator, counts periods, signals completion.
//  Sits between the control requesters and the generator instance.
// PARAMETERS
//  N_REQ          4   number of requesters (2..8)
//  PERIOD_CYCLES  32  generator cycles per waveform period (from package)
//  CNT_W          8   width of per-request period count
// PORTS
//  clk          in   1            system clock, rising edge
//  reset_n      in   1            asynchronous reset, active-low
//  req_valid    in   N_REQ        request pending, held until req_ready seen
//  req_mode     in   2*N_REQ      per-requester mode: 01 saw up, 10 saw down, 11 triangle, 00 none
//  req_step     in   4*N_REQ      per-requester step_size
//  req_periods  in   CNT_W*N_REQ  per-requester burst length in periods
//  req_ready    out  N_REQ        one-hot, 1-cycle pulse: request accepted, fields captured
//  done         out  N_REQ        one-hot, 1-cycle pulse: burst finished
//  gen_reset    out  1            active-high sync reset to the generator
//  gen_mode     out  2            mode to the generator
//  gen_step     out  4            step_size to the generator
//  busy         out  1            high in LOAD/RUN/DONE
//  owner        out  $clog2(N_REQ)  index of the current/last granted requester
// BEHAVIOUR
//  Reset values: req_ready=0, done=0, gen_reset=1, gen_mode=00, gen_step=0, busy=0, owner=0, rr pointer=0, state=IDLE.
//  FSM IDLE->LOAD->RUN->DONE->IDLE. All outputs registered.
//  IDLE: gen_reset=1, gen_mode=00. On any req_valid, pick winner i by round robin from pointer.
//   At that edge: capture mode/step/periods[i], owner=i, pointer=i+1 mod N_REQ.
//   Next cycle: req_ready[i]=1 and state=LOAD.
//  Zero burst: periods==0 or mode==00 -> IDLE->DONE directly. req_ready and done are 1 cycle apart.
//   gen_reset is never deasserted.
//  LOAD, 1 cycle: gen_reset=1, gen_mode/gen_step = captured values, so the generator resets in the right mode.
//  RUN: gen_reset=0. cyc counter 0..PERIOD_CYCLES-1 wraps and decrements remaining periods.
//   RUN lasts exactly periods*PERIOD_CYCLES cycles, then DONE.
//   Captured values hold for the whole burst; input changes are ignored.
//  DONE, 1 cycle: done[owner]=1, gen_reset=1, gen_mode=00, gen_step=0. Then IDLE.
//   Arbitration restarts in IDLE, 1 cycle later.
//  Requester must drop req_valid within 2 cycles after req_ready; a still-high valid in IDLE is a new request.
//  Valid deasserted before grant: request silently withdrawn.
//  Only one burst is outstanding; other requests wait, there is no queue.
//  Reset mid-burst: async, all outputs to reset values, no done pulse, burst lost.
// CONFIGURATION
//  WAVE_SEQ_ABORT_EN defined:
//   Adds input abort (1) and output aborted (1).
//   abort=1 in LOAD/RUN -> DONE next cycle with done[owner]=1 and aborted=1 for that cycle; else aborted=0.
//   abort is ignored in IDLE/DONE.
//  Undefined: ports absent, every burst runs to completion.
// STRUCTURE
//  wave_pkg holds:
//   mode constants MODE_NONE=2'b00, SAW_UP=2'b01, SAW_DOWN=2'b10, TRIANGLE=2'b11
//   PERIOD_CYCLES=32
//   typedef enum seq_state_t {IDLE, LOAD, RUN, DONE}
//  Sub-module rr_arbiter (N_REQ): req vector + pointer -> one-hot grant + index, purely combinational.
//  FSM and counters stay in wave_sequencer.
// TESTING
//  1 reset_n=0 mid-stream -> gen_reset=1, gen_mode=00, busy=0, done=0 at once; held until release.
//  2 req0: mode=01, step=4, periods=2 -> req_ready[0] pulse, 1 LOAD cycle with mode=01/step=4,
//    gen_reset low exactly 64 cycles, done[0] pulse, busy low 1 cycle later.
//  3 all 4 valid, periods=1, re-raised after each done -> grant order 0,1,2,3,0.
//    owner tracks the grant; no requester is skipped.
//  4 req2 periods=0, then req1 mode=00 -> each gets req_ready then done 1 cycle later.
//    gen_reset stays 1 throughout.
//  5 reset_n low at RUN cycle 10 of a 3-period burst -> no done; after release, req1 alone is granted from pointer 0.
//  6 WAVE_SEQ_ABORT_EN: abort at RUN cycle 5 -> next cycle done[owner]=1, aborted=1, gen_reset=1, then IDLE.

Source files
------------

// File: rtl/wave_pkg.sv
// Shared types and constants for the wave sequencer: generator modes, period length, FSM states.
package wave_pkg;

  localparam logic [1:0] MODE_NONE = 2'b00;
  localparam logic [1:0] SAW_UP    = 2'b01;
  localparam logic [1:0] SAW_DOWN  = 2'b10;
  localparam logic [1:0] TRIANGLE  = 2'b11;

  localparam int unsigned PERIOD_CYCLES = 32;
  localparam int unsigned CYC_W         = $clog2(PERIOD_CYCLES);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} seq_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the first asserted request at or after ptr_i wins.
module rr_arbiter #(
  parameter int unsigned  N_REQ = 4,
  localparam int unsigned IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N_REQ-1:0] grant_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  always_comb begin
    int unsigned sel;
    sel     = 0;
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      sel = (32'(ptr_i) + k) % N_REQ;
      if (!any_o && req_i[sel[IDX_W-1:0]]) begin
        any_o                   = 1'b1;
        grant_o[sel[IDX_W-1:0]] = 1'b1;
        idx_o                   = sel[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/wave_sequencer.sv
// Round-robin burst scheduler sharing one wave generator among N_REQ requesters.
// Optional WAVE_SEQ_ABORT_EN adds an abort input and an aborted status pulse.
module wave_sequencer
  import wave_pkg::*;
#(
  parameter int unsigned  N_REQ = 4,
  parameter int unsigned  CNT_W = 8,
  localparam int unsigned IDX_W = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [2*N_REQ-1:0]     req_mode,
  input  logic [4*N_REQ-1:0]     req_step,
  input  logic [CNT_W*N_REQ-1:0] req_periods,
  output logic [N_REQ-1:0]       req_ready,
  output logic [N_REQ-1:0]       done,
  output logic                   gen_reset,
  output logic [1:0]             gen_mode,
  output logic [3:0]             gen_step,
  output logic                   busy,
`ifdef WAVE_SEQ_ABORT_EN
  input  logic                   abort,
  output logic                   aborted,
`endif
  output logic [IDX_W-1:0]       owner
);

  seq_state_t state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d, owner_q, owner_d;
  logic [1:0]       mode_q, mode_d;
  logic [3:0]       step_q, step_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [CYC_W-1:0] cyc_q, cyc_d;
  logic             zero_q, zero_d;

  logic [N_REQ-1:0] req_ready_q, req_ready_d, done_q, done_d;
  logic             gen_reset_q, gen_reset_d, busy_q, busy_d;
  logic [1:0]       gen_mode_q, gen_mode_d;
  logic [3:0]       gen_step_q, gen_step_d;

  logic [N_REQ-1:0] arb_req, arb_grant;
  logic [IDX_W-1:0] arb_idx;
  logic             arb_any;
  logic [1:0]       sel_mode;
  logic [3:0]       sel_step;
  logic [CNT_W-1:0] sel_periods;
  logic             abort_hit;

  // Arbitration only runs in IDLE so a held valid never steals a running burst.
  assign arb_req = (state_q == IDLE) ? req_valid : '0;

  rr_arbiter #(
    .N_REQ (N_REQ)
  ) u_arb (
    .req_i   (arb_req),
    .ptr_i   (ptr_q),
    .grant_o (arb_grant),
    .idx_o   (arb_idx),
    .any_o   (arb_any)
  );

  assign sel_mode    = req_mode[2*int'(arb_idx) +: 2];
  assign sel_step    = req_step[4*int'(arb_idx) +: 4];
  assign sel_periods = req_periods[CNT_W*int'(arb_idx) +: CNT_W];

`ifdef WAVE_SEQ_ABORT_EN
  logic aborted_q, aborted_d;
  assign abort_hit = abort && ((state_q == LOAD) || (state_q == RUN));
`else
  assign abort_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      owner_q     <= '0;
      mode_q      <= MODE_NONE;
      step_q      <= '0;
      rem_q       <= '0;
      cyc_q       <= '0;
      zero_q      <= 1'b0;
      req_ready_q <= '0;
      done_q      <= '0;
      gen_reset_q <= 1'b1;
      gen_mode_q  <= MODE_NONE;
      gen_step_q  <= '0;
      busy_q      <= 1'b0;
`ifdef WAVE_SEQ_ABORT_EN
      aborted_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      mode_q      <= mode_d;
      step_q      <= step_d;
      rem_q       <= rem_d;
      cyc_q       <= cyc_d;
      zero_q      <= zero_d;
      req_ready_q <= req_ready_d;
      done_q      <= done_d;
      gen_reset_q <= gen_reset_d;
      gen_mode_q  <= gen_mode_d;
      gen_step_q  <= gen_step_d;
      busy_q      <= busy_d;
`ifdef WAVE_SEQ_ABORT_EN
      aborted_q   <= aborted_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    mode_d  = mode_q;
    step_d  = step_q;
    rem_d   = rem_q;
    cyc_d   = cyc_q;
    zero_d  = zero_q;
    unique case (state_q)
      IDLE: begin
        if (arb_any) begin
          owner_d = arb_idx;
          ptr_d   = (arb_idx == IDX_W'(N_REQ - 1)) ? '0 : arb_idx + 1'b1;
          mode_d  = sel_mode;
          step_d  = sel_step;
          rem_d   = sel_periods;
          if ((sel_periods == '0) || (sel_mode == MODE_NONE)) begin
            state_d = DONE;
            zero_d  = 1'b1;
          end else begin
            state_d = LOAD;
          end
        end
      end
      LOAD: begin
        cyc_d   = '0;
        state_d = abort_hit ? DONE : RUN;
      end
      RUN: begin
        cyc_d = cyc_q + 1'b1;
        if (cyc_q == CYC_W'(PERIOD_CYCLES - 1)) begin
          cyc_d = '0;
          rem_d = rem_q - 1'b1;
          if (rem_q == CNT_W'(1)) state_d = DONE;
        end
        if (abort_hit) state_d = DONE;
      end
      DONE: begin
        // A zero burst spends an extra DONE cycle so ready and done land one cycle apart.
        if (zero_q) zero_d = 1'b0;
        else        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready_d = '0;
    if ((state_q == IDLE) && arb_any) req_ready_d = arb_grant;
    done_d = '0;
    if ((state_d == DONE) && !zero_d) done_d[owner_d] = 1'b1;
    gen_reset_d = (state_d != RUN);
    gen_mode_d  = ((state_d == LOAD) || (state_d == RUN)) ? mode_d : MODE_NONE;
    gen_step_d  = ((state_d == LOAD) || (state_d == RUN)) ? step_d : 4'd0;
    busy_d      = (state_d != IDLE);
`ifdef WAVE_SEQ_ABORT_EN
    aborted_d   = abort_hit;
`endif
  end

  assign req_ready = req_ready_q;
  assign done      = done_q;
  assign gen_reset = gen_reset_q;
  assign gen_mode  = gen_mode_q;
  assign gen_step  = gen_step_q;
  assign busy      = busy_q;
  assign owner     = owner_q;
`ifdef WAVE_SEQ_ABORT_EN
  assign aborted   = aborted_q;
`endif

endmodule
